// File: rtl/io_stim_gen.sv
// io_stim_gen
//   Stimulus source for the sc_computer input ports. It drives NCH channels of
//   WIDTH bits each. Every channel has its own update mode and period. The block
//   also sequences the DUT reset: after start it holds dut_resetn low for
//   RST_CYCLES cycles and then enters RUN.
//
//   Optional feature macro: STIM_LFSR_EN
//     defined   -> mode 2'b11 is a Galois LFSR (shifts right, 0 is replaced by 1)
//     undefined -> mode 2'b11 behaves as HOLD and no LFSR logic is built
//
// Ports
//   mem_clk     in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   pulse: run the reset sequence, then RUN
//   stop        in   pulse: return to IDLE (wins over start)
//   pause       in   level: freeze channel updates and run_cycles while in RUN
//   cfg_we      in   write the channel config this cycle
//   cfg_ch      in   channel index for the config write (index >= NCH is ignored)
//   cfg_mode    in   00 HOLD, 01 COUNT, 10 TOGGLE, 11 LFSR
//   cfg_period  in   update every max(cfg_period,1) unpaused RUN cycles
//   cfg_init    in   value loaded into the channel on a config write
//   ch_out      out  channel k at [k*WIDTH +: WIDTH]
//   dut_resetn  out  registered DUT reset, active low, high only in RUN
//   running     out  registered, 1 in RUN (including while paused)
//   run_cycles  out  number of unpaused RUN cycles, wraps, cleared only by resetn

module io_stim_gen #(
  parameter int NCH        = 2,
  parameter int WIDTH      = 4,
  parameter int PW         = 8,
  parameter int RST_CYCLES = 5
) (
  input  logic                                   mem_clk,
  input  logic                                   resetn,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic                                   pause,
  input  logic                                   cfg_we,
  input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                             cfg_mode,
  input  logic [PW-1:0]                          cfg_period,
  input  logic [WIDTH-1:0]                       cfg_init,
  output logic [NCH*WIDTH-1:0]                   ch_out,
  output logic                                   dut_resetn,
  output logic                                   running,
  output logic [31:0]                            run_cycles
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_COUNT  = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;
  localparam logic [1:0] MODE_LFSR   = 2'b11;

`ifdef STIM_LFSR_EN
  // Maximal-length Galois polynomials with the x^WIDTH term removed; that term
  // is added back as the MSB of the tap mask below.
  function automatic logic [31:0] lfsr_poly(input int w);
    case (w)
      2:  lfsr_poly = 32'h0000_0001;
      3:  lfsr_poly = 32'h0000_0002;
      4:  lfsr_poly = 32'h0000_0004;
      5:  lfsr_poly = 32'h0000_0004;
      6:  lfsr_poly = 32'h0000_0010;
      7:  lfsr_poly = 32'h0000_0020;
      8:  lfsr_poly = 32'h0000_0038;
      9:  lfsr_poly = 32'h0000_0010;
      10: lfsr_poly = 32'h0000_0040;
      11: lfsr_poly = 32'h0000_0100;
      12: lfsr_poly = 32'h0000_0029;
      13: lfsr_poly = 32'h0000_000D;
      14: lfsr_poly = 32'h0000_0015;
      15: lfsr_poly = 32'h0000_2000;
      16: lfsr_poly = 32'h0000_5008;
      17: lfsr_poly = 32'h0000_2000;
      18: lfsr_poly = 32'h0000_0400;
      19: lfsr_poly = 32'h0000_0023;
      20: lfsr_poly = 32'h0001_0000;
      21: lfsr_poly = 32'h0004_0000;
      22: lfsr_poly = 32'h0010_0000;
      23: lfsr_poly = 32'h0002_0000;
      24: lfsr_poly = 32'h0061_0000;
      25: lfsr_poly = 32'h0020_0000;
      26: lfsr_poly = 32'h0000_0023;
      27: lfsr_poly = 32'h0000_0013;
      28: lfsr_poly = 32'h0100_0000;
      29: lfsr_poly = 32'h0400_0000;
      30: lfsr_poly = 32'h0000_0029;
      31: lfsr_poly = 32'h0800_0000;
      32: lfsr_poly = 32'h0020_0003;
      default: lfsr_poly = 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]      LFSR_POLY = lfsr_poly(WIDTH);
  localparam logic [WIDTH-1:0] LFSR_MSB  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] LFSR_MASK = LFSR_MSB ^ LFSR_POLY[WIDTH-1:0];
`endif

  // Value a channel takes when its period expires.
  function automatic logic [WIDTH-1:0] next_val(input logic [1:0] m,
                                                input logic [WIDTH-1:0] v);
    case (m)
      MODE_COUNT:  next_val = v + WIDTH'(1);
      MODE_TOGGLE: next_val = ~v;
`ifdef STIM_LFSR_EN
      MODE_LFSR: begin
        if (v == '0) next_val = WIDTH'(1);
        else         next_val = (v >> 1) ^ (v[0] ? LFSR_MASK : '0);
      end
`endif
      default:     next_val = v;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RSTSEQ, S_RUN} state_t;

  state_t           state;
  logic [RCW-1:0]   rst_cnt;
  logic             tick_en;

  assign tick_en = (state == S_RUN) && !pause;

  // Run-control FSM. dut_resetn and running are registered together with the
  // state, so they change on the same edge on which the state changes.
  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      rst_cnt    <= '0;
      dut_resetn <= 1'b0;
      running    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            if (RST_CYCLES == 0) begin
              state      <= S_RUN;
              dut_resetn <= 1'b1;
              running    <= 1'b1;
            end else begin
              state   <= S_RSTSEQ;
              rst_cnt <= '0;
            end
          end
        end
        S_RSTSEQ: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
            state      <= S_RUN;
            dut_resetn <= 1'b1;
            running    <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RCW'(1);
          end
        end
        S_RUN: begin
          if (stop) begin
            state      <= S_IDLE;
            dut_resetn <= 1'b0;
            running    <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          dut_resetn <= 1'b0;
          running    <= 1'b0;
        end
      endcase
    end
  end

  // Unpaused RUN cycle counter. It survives stop and is cleared only by resetn.
  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) run_cycles <= '0;
    else if (tick_en) run_cycles <= run_cycles + 32'd1;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [1:0]       mode;
    logic [PW-1:0]    period;
    logic [PW-1:0]    cnt;
    logic [WIDTH-1:0] val;
    logic             hit;

    // Periods 0 and 1 both mean "update every cycle".
    assign hit = (period <= PW'(1)) ? (cnt == '0) : (cnt == period - PW'(1));

    // Per-channel state. A config write takes priority over a tick on the same
    // edge, and it restarts the period from zero.
    always_ff @(posedge mem_clk or negedge resetn) begin
      if (!resetn) begin
        mode   <= MODE_HOLD;
        period <= '0;
        cnt    <= '0;
        val    <= '0;
      end else if (cfg_we && (cfg_ch == CHW'(k))) begin
        mode   <= cfg_mode;
        period <= cfg_period;
        cnt    <= '0;
        val    <= cfg_init;
      end else if (tick_en) begin
        if (hit) begin
          cnt <= '0;
          val <= next_val(mode, val);
        end else begin
          cnt <= cnt + PW'(1);
        end
      end
    end

    assign ch_out[k*WIDTH +: WIDTH] = val;
  end

endmodule

// File: tb/tb_io_stim_gen.sv
// tb_io_stim_gen
//   Directed bench for io_stim_gen with NCH=3, WIDTH=4, PW=8, RST_CYCLES=5.
//   Channel 2 is a spare channel. It also lets an out-of-range index (3) be
//   driven on the 2-bit cfg_ch port.
//   Expected values are worked out by hand from the channel periods.
//   If the bench is compiled with STIM_LFSR_EN, the mode-11 expectations
//   switch to the LFSR sequence.

module tb_io_stim_gen;

  localparam int NCH        = 3;
  localparam int WIDTH      = 4;
  localparam int PW         = 8;
  localparam int RST_CYCLES = 5;

  logic                 mem_clk    = 1'b0;
  logic                 resetn     = 1'b0;
  logic                 start      = 1'b0;
  logic                 stop       = 1'b0;
  logic                 pause      = 1'b0;
  logic                 cfg_we     = 1'b0;
  logic [1:0]           cfg_ch     = '0;
  logic [1:0]           cfg_mode   = '0;
  logic [PW-1:0]        cfg_period = '0;
  logic [WIDTH-1:0]     cfg_init   = '0;
  logic [NCH*WIDTH-1:0] ch_out;
  logic                 dut_resetn;
  logic                 running;
  logic [31:0]          run_cycles;

  int errCount   = 0;
  int checkCount = 0;

  io_stim_gen #(
    .NCH(NCH), .WIDTH(WIDTH), .PW(PW), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .mem_clk(mem_clk), .resetn(resetn), .start(start), .stop(stop),
    .pause(pause), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_init(cfg_init), .ch_out(ch_out),
    .dut_resetn(dut_resetn), .running(running), .run_cycles(run_cycles)
  );

  always #5 mem_clk = ~mem_clk;

  // Hand-derived checkpoints for the COUNT/TOGGLE run. n is the RUN edge index.
  int         cpN   [9] = '{13, 14, 19, 20, 28, 40, 60, 210, 224};
  logic [3:0] cpCh0 [9] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'hF, 4'h0};
  logic [3:0] cpCh1 [9] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};

  // Expected 4-bit Galois sequence (mask 4'hC) starting from the 0->1 seed.
  logic [3:0] lfsrSeq [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                               4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

  // Advance n clock edges and settle 1 time unit after the last edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge mem_clk);
    #1;
  endtask

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] chVal(input int k);
    return ch_out[k*WIDTH +: WIDTH];
  endfunction

  task automatic cfgWrite(input logic [1:0] ch, input logic [1:0] mode,
                          input logic [PW-1:0] period, input logic [WIDTH-1:0] init);
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = period;
    cfg_init   = init;
    cfg_we     = 1'b1;
    applyStimulus(1);
    cfg_we     = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
  endtask

  // Wait at most 20 cycles for RUN. A timeout shows up as a failed check.
  task automatic waitRunning(input string tag);
    int guard = 0;
    while (!running && guard < 20) begin
      applyStimulus(1);
      guard++;
    end
    checkOutput(tag, 32'(running), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int badCycles;
    int lowCount;
    int idx;

    // Reset values, then 100 quiet cycles with no start.
    applyStimulus(2);
    checkOutput("rst_ch_out", 32'(ch_out), 32'd0);
    checkOutput("rst_dut_resetn", 32'(dut_resetn), 32'd0);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_run_cycles", run_cycles, 32'd0);
    resetn = 1'b1;
    badCycles = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1);
      if (ch_out != '0 || dut_resetn || running) badCycles++;
    end
    checkOutput("idle_quiet", 32'(badCycles), 32'd0);

    // Ch0 is COUNT with period 14; ch1 is TOGGLE with period 20.
    cfgWrite(2'd0, 2'b01, 8'd14, 4'h0);
    cfgWrite(2'd1, 2'b10, 8'd20, 4'h0);
    pulseStart();
    lowCount = 0;
    while (dut_resetn == 1'b0 && lowCount < 20) begin
      lowCount++;
      applyStimulus(1);
    end
    checkOutput("rstseq_low_cycles", 32'(lowCount), 32'd5);
    checkOutput("rstseq_running", 32'(running), 32'd1);
    idx = 0;
    for (int n = 1; n <= 224; n++) begin
      applyStimulus(1);
      if (idx < 9 && n == cpN[idx]) begin
        checkOutput($sformatf("count_ch0_n%0d", n), 32'(chVal(0)), 32'(cpCh0[idx]));
        checkOutput($sformatf("toggle_ch1_n%0d", n), 32'(chVal(1)), 32'(cpCh1[idx]));
        checkOutput($sformatf("run_cycles_n%0d", n), run_cycles, 32'(n));
        idx++;
      end
    end
    // The stop edge is still a RUN edge, so it also ticks (RUN edge 225).
    pulseStop();
    checkOutput("stop_running", 32'(running), 32'd0);
    checkOutput("stop_dut_resetn", 32'(dut_resetn), 32'd0);
    checkOutput("stop_run_cycles", run_cycles, 32'd225);
    checkOutput("stop_ch0", 32'(chVal(0)), 32'h0);
    checkOutput("stop_ch1", 32'(chVal(1)), 32'hF);
    applyStimulus(3);
    checkOutput("idle_hold_ch1", 32'(chVal(1)), 32'hF);
    checkOutput("idle_hold_run_cycles", run_cycles, 32'd225);

    // Period 0 updates every cycle; pause freezes the channel and run_cycles.
    cfgWrite(2'd0, 2'b01, 8'd0, 4'h0);
    cfgWrite(2'd1, 2'b00, 8'd0, 4'h5);
    pulseStart();
    waitRunning("run2_timeout");
    checkOutput("p0_start_ch0", 32'(chVal(0)), 32'h0);
    applyStimulus(5);
    checkOutput("p0_ch0_5", 32'(chVal(0)), 32'h5);
    checkOutput("p0_runc_5", run_cycles, 32'd230);
    pause = 1'b1;
    applyStimulus(10);
    checkOutput("pause_ch0", 32'(chVal(0)), 32'h5);
    checkOutput("pause_runc", run_cycles, 32'd230);
    checkOutput("pause_running", 32'(running), 32'd1);
    pause = 1'b0;
    applyStimulus(3);
    checkOutput("resume_ch0", 32'(chVal(0)), 32'h8);
    checkOutput("resume_runc", run_cycles, 32'd233);
    checkOutput("hold_ch1", 32'(chVal(1)), 32'h5);

    // start+stop together in IDLE; stop during the reset sequence.
    pulseStop();
    checkOutput("stop2_ch0", 32'(chVal(0)), 32'h9);
    start = 1'b1;
    stop  = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    stop  = 1'b0;
    applyStimulus(6);
    checkOutput("startstop_running", 32'(running), 32'd0);
    checkOutput("startstop_dut_resetn", 32'(dut_resetn), 32'd0);
    pulseStart();
    applyStimulus(2);
    checkOutput("rstseq_mid_dut_resetn", 32'(dut_resetn), 32'd0);
    pulseStop();
    applyStimulus(6);
    checkOutput("rstseq_stop_running", 32'(running), 32'd0);
    checkOutput("rstseq_stop_dut_resetn", 32'(dut_resetn), 32'd0);
    checkOutput("rstseq_stop_runc", run_cycles, 32'd234);

    // A config write on the tick edge wins; then a full period passes before the next update.
    cfgWrite(2'd0, 2'b01, 8'd4, 4'h0);
    pulseStart();
    waitRunning("run3_timeout");
    applyStimulus(3);
    checkOutput("pretick_ch0", 32'(chVal(0)), 32'h0);
    cfgWrite(2'd0, 2'b01, 8'd4, 4'h7);
    checkOutput("cfg_wins_ch0", 32'(chVal(0)), 32'h7);
    applyStimulus(3);
    checkOutput("cfg_period_hold_ch0", 32'(chVal(0)), 32'h7);
    applyStimulus(1);
    checkOutput("cfg_period_tick_ch0", 32'(chVal(0)), 32'h8);
    pulseStop();
    checkOutput("before_badch", 32'(ch_out), 32'h058);
    cfgWrite(2'd3, 2'b10, 8'd1, 4'hA);
    applyStimulus(2);
    checkOutput("badch_ignored", 32'(ch_out), 32'h058);

    // Mode 11 with init 0 and period 1 on ch2.
    cfgWrite(2'd2, 2'b11, 8'd1, 4'h0);
    pulseStart();
    waitRunning("run4_timeout");
    checkOutput("m11_start_ch2", 32'(chVal(2)), 32'h0);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1);
`ifdef STIM_LFSR_EN
      checkOutput($sformatf("lfsr_ch2_k%0d", k), 32'(chVal(2)), 32'(lfsrSeq[(k-1) % 15]));
`else
      checkOutput($sformatf("m11_hold_ch2_k%0d", k), 32'(chVal(2)), 32'h0);
`endif
    end
    checkOutput("m11_ch1_unaffected", 32'(chVal(1)), 32'h5);

    // Asynchronous reset in the middle of RUN clears everything.
    resetn = 1'b0;
    #1;
    checkOutput("rst2_ch_out", 32'(ch_out), 32'd0);
    checkOutput("rst2_run_cycles", run_cycles, 32'd0);
    checkOutput("rst2_running", 32'(running), 32'd0);
    checkOutput("rst2_dut_resetn", 32'(dut_resetn), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
